axis_tx_frame_arbiter: RTL and testbench
========================================

// Module: axis_tx_frame_arbiter
// PURPOSE
//  Frame-granular round-robin arbiter that shares the single 10G MAC TX AXI-stream
//  (64-bit data, 8-bit keep) between N requesters, e.g. the loopback FIFO and local packet generators.
//  Sits between the requester FIFOs and the eth_mac_10g_fifo TX input.
//  Grant is held from first beat to tlast, so frames are never interleaved.
// PARAMETERS
//  PORTS        2     number of requesters, 2..8
//  TIMEOUT      1024  stall cycles before forced frame abort (ARB_TIMEOUT_EN only), 2..65535
// PORTS
//  clk                 in   1         TX logic clock, 156.25 MHz
//  rst_n               in   1         async active-low reset
//  in_axis_tdata       in   PORTS*64  per-port data, port i at [i*64 +: 64]
//  in_axis_tkeep       in   PORTS*8   per-port byte enables
//  in_axis_tvalid      in   PORTS     per-port valid
//  in_axis_tready      out  PORTS     per-port ready
//  in_axis_tlast       in   PORTS     per-port end of frame
//  in_axis_tuser       in   PORTS     per-port bad-frame flag
//  out_axis_tdata      out  64        to MAC TX
//  out_axis_tkeep      out  8         to MAC TX
//  out_axis_tvalid     out  1         to MAC TX
//  out_axis_tready     in   1         from MAC TX
//  out_axis_tlast      out  1         to MAC TX
//  out_axis_tuser      out  1         to MAC TX; 1 = MAC drops the frame
//  grant               out  PORTS     one-hot current owner, 0 when idle
//  busy                out  1         frame in progress
//  timeout_err         out  1         1-cycle pulse on forced abort (tied 0 without macro)
// BEHAVIOUR
//  - Reset: every output 0 (in_axis_tready, out_axis_tvalid, grant, busy, timeout_err).
//    State = IDLE; round-robin pointer = 0.
//  - FSM IDLE: any in_axis_tvalid -> pick the first requesting port at or after the pointer
//    (wrapping), register grant -> ACTIVE. One cycle of arbitration bubble per frame.
//  - FSM ACTIVE: in_axis_tready[g] = output stage can accept; other ports' tready = 0.
//    Each beat accepted on port g when tvalid & tready.
//    Accepted beat with tlast -> pointer = g+1 mod PORTS, grant = 0 -> IDLE.
//  - Output stage: registered with a 2-entry skid buffer.
//    Latency is 1 cycle from input acceptance to out_axis_tvalid.
//    Full throughput: 1 beat/clk while out_axis_tready = 1.
//  - out_axis_* is held stable while tvalid & !tready (AXI rule). tvalid never drops without a handshake.
//  - Single-beat frame (tvalid & tlast on the first beat) is legal; the FSM returns to IDLE the next cycle.
//  - A request arriving on the same cycle a frame ends waits for the IDLE arbitration.
//    A port requesting continuously cannot starve others: worst-case wait is PORTS-1 frames.
//  - Requester deasserting tvalid mid-frame: grant is held and bubbles pass, with no timeout without the macro.
//  - Async reset mid-frame: the frame is truncated. Skid contents are discarded and outputs return to 0 immediately.
//  - busy = (state != IDLE) | skid buffer non-empty.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - 16-bit stall counter in ACTIVE; it counts cycles with tvalid[g] = 0 and clears on every accepted beat.
//   - Reaching TIMEOUT enters ABORT: inject one beat (tdata 0, tkeep 8'h01, tlast 1, tuser 1).
//   - After the output accepts it: pulse timeout_err, advance the pointer -> DRAIN.
//   - DRAIN: tready[g] = 1, discard beats up to and including the requester's tlast -> IDLE.
//  ARB_TIMEOUT_EN undefined: no counter and no ABORT/DRAIN states; timeout_err tied 0; TIMEOUT ignored.
// STRUCTURE
//  - Shared package eth_arb_pkg:
//    - FSM state encoding (IDLE, ACTIVE, ABORT, DRAIN)
//    - AXIS_DATA_W = 64, AXIS_KEEP_W = 8
//    - abort-beat constants
//  - Sub-module arb_rr_select: combinational round-robin pick.
//    Inputs: req[PORTS], pointer. Outputs: one-hot gnt, gnt_valid.
//    Reusable by the RX-side distributor.
//  - Top holds the FSM, the output mux, the skid buffer and the optional stall counter.
// TESTING
//  1 Reset/idle: rst_n=0 with all tvalid=1 -> all outputs 0. Release: grant=2'b01 after 1 cycle, data appears 1 cycle later.
//  2 Round robin: ports 0 and 1 each send back-to-back 3-beat frames with out tready=1.
//    -> output frames alternate 0,1,0,1, never interleaved; beats out contiguous.
//  3 Backpressure: out_axis_tready toggles 1010 during an 8-beat frame.
//    -> all 8 beats delivered in order, no loss or duplicate; data is stable while stalled.
//  4 Single-beat frames: port 1 sends tkeep=8'h0F, tlast=1 repeatedly and port 0 is idle.
//    -> one output beat per 2 cycles, tkeep=8'h0F passed through.
//  5 Mid-frame reset: assert rst_n=0 on beat 3 of 6 -> outputs 0 in the same cycle.
//    After release, the next frame starts cleanly from pointer 0.
//  6 (ARB_TIMEOUT_EN, TIMEOUT=16) port 0 stalls after beat 2 for 20 cycles.
//    -> abort beat (tuser=1, tlast=1) out, timeout_err pulse, remainder drained, port 1 granted next.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet AXI-stream frame arbiters.
package eth_arb_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = 8;

  // Arbiter FSM encoding
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StAbort  = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    logic                   user;
  } axis_beat_t;

  // Beat injected when a stalled frame is forcibly terminated; tuser makes the MAC drop it.
  localparam logic [AXIS_DATA_W-1:0] ABORT_TDATA = '0;
  localparam logic [AXIS_KEEP_W-1:0] ABORT_TKEEP = 8'h01;
  localparam axis_beat_t ABORT_BEAT = '{data: ABORT_TDATA, keep: ABORT_TKEEP,
                                        last: 1'b1, user: 1'b1};

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module arb_rr_select #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned PtrW  = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PtrW-1:0]  ptr,
  output logic [PORTS-1:0] gnt,
  output logic             gnt_valid
);

  logic [2*PORTS-1:0] req_dbl;
  logic [2*PORTS-1:0] gnt_dbl;
  logic [PORTS-1:0]   rot;
  logic [PORTS-1:0]   low;
  logic               unused_bits;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  assign req_dbl   = {req, req} >> ptr;
  assign rot       = req_dbl[PORTS-1:0];
  assign low       = rot & (~rot + PORTS'(1));
  assign gnt_dbl   = {low, low} << ptr;
  assign gnt       = gnt_dbl[2*PORTS-1:PORTS];
  assign gnt_valid = |req;

  assign unused_bits = ^{req_dbl[2*PORTS-1:PORTS], gnt_dbl[PORTS-1:0]};

endmodule

// File: rtl/axis_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the 10G MAC TX stream through a skid buffer.
// Define ARB_TIMEOUT_EN to abort frames whose owner stalls for TIMEOUT cycles.
module axis_tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int unsigned PORTS   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORTS*AXIS_DATA_W-1:0] in_axis_tdata,
  input  logic [PORTS*AXIS_KEEP_W-1:0] in_axis_tkeep,
  input  logic [PORTS-1:0]             in_axis_tvalid,
  output logic [PORTS-1:0]             in_axis_tready,
  input  logic [PORTS-1:0]             in_axis_tlast,
  input  logic [PORTS-1:0]             in_axis_tuser,
  output logic [AXIS_DATA_W-1:0]       out_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]       out_axis_tkeep,
  output logic                         out_axis_tvalid,
  input  logic                         out_axis_tready,
  output logic                         out_axis_tlast,
  output logic                         out_axis_tuser,
  output logic [PORTS-1:0]             grant,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned PtrW = $clog2(PORTS);

  logic [1:0]       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_next, gidx;
  logic [PORTS-1:0] rr_gnt;
  logic             rr_valid;

  axis_beat_t sel_beat, stage_beat, out_q, skid_q;
  logic       sel_valid, stage_valid, push, can_accept;
  logic       out_valid_q, skid_valid_q;

  arb_rr_select #(
    .PORTS (PORTS),
    .PtrW  (PtrW)
  ) u_rr_select (
    .req       (in_axis_tvalid),
    .ptr       (ptr_q),
    .gnt       (rr_gnt),
    .gnt_valid (rr_valid)
  );

  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    gidx      = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        sel_valid     = in_axis_tvalid[i];
        sel_beat.data = in_axis_tdata[i*AXIS_DATA_W +: AXIS_DATA_W];
        sel_beat.keep = in_axis_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W];
        sel_beat.last = in_axis_tlast[i];
        sel_beat.user = in_axis_tuser[i];
        gidx          = PtrW'(i);
      end
    end
  end

  assign ptr_next = (gidx == PtrW'(PORTS - 1)) ? '0 : gidx + PtrW'(1);

  // Skid slot free means the stage can always absorb one more beat, even if the MAC stalls.
  assign can_accept = !skid_valid_q;
  assign push       = stage_valid && can_accept;

  always_comb begin
    stage_valid = 1'b0;
    stage_beat  = sel_beat;
    if (state_q == StActive) stage_valid = sel_valid;
`ifdef ARB_TIMEOUT_EN
    if (state_q == StAbort) begin
      stage_valid = 1'b1;
      stage_beat  = ABORT_BEAT;
    end
`endif
  end

  always_comb begin
    in_axis_tready = '0;
    if (state_q == StActive && can_accept) in_axis_tready = grant_q;
`ifdef ARB_TIMEOUT_EN
    if (state_q == StDrain) in_axis_tready = grant_q;
`endif
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_hit;
  logic        timeout_q;

  assign stall_hit = (state_q == StActive) && !sel_valid && (stall_q == 16'(TIMEOUT - 1));

  always_comb begin
    stall_d = stall_q;
    if (state_q != StActive || push || stall_hit) stall_d = '0;
    else if (!sel_valid)                          stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= (state_q == StAbort) && push;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (rr_valid) begin
          grant_d = rr_gnt;
          state_d = StActive;
        end
      end
      StActive: begin
        if (push && stage_beat.last) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = StIdle;
        end
`ifdef ARB_TIMEOUT_EN
        else if (stall_hit) begin
          state_d = StAbort;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      StAbort: begin
        if (push) begin
          ptr_d   = ptr_next;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (sel_valid && sel_beat.last) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_axis_tready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= push;
        if (push) out_q <= stage_beat;
      end
    end else if (push) begin
      skid_q       <= stage_beat;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_axis_tdata  = out_q.data;
  assign out_axis_tkeep  = out_q.keep;
  assign out_axis_tlast  = out_q.last;
  assign out_axis_tuser  = out_q.user;
  assign out_axis_tvalid = out_valid_q;
  assign grant           = grant_q;
  assign busy            = (state_q != StIdle) || out_valid_q || skid_valid_q;

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Self-checking bench for axis_tx_frame_arbiter: directed steps plus a randomized frame mix
// compared against a frame-level round-robin model.
module tb_axis_tx_frame_arbiter;

  localparam int NP = 2;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic [NP*64-1:0] in_tdata;
  logic [NP*8-1:0]  in_tkeep;
  logic [NP-1:0]   in_tvalid;
  logic [NP-1:0]   in_tready;
  logic [NP-1:0]   in_tlast;
  logic [NP-1:0]   in_tuser;
  logic [63:0]     out_tdata;
  logic [7:0]      out_tkeep;
  logic            out_valid;
  logic            out_tready;
  logic            out_tlast;
  logic            out_tuser;
  logic [NP-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t src_q [NP][$];
  int    flen  [NP][$];
  beat_t exp_q [$];
  int    pos   [NP];

  axis_tx_frame_arbiter #(
    .PORTS   (NP),
    .TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_axis_tdata   (in_tdata),
    .in_axis_tkeep   (in_tkeep),
    .in_axis_tvalid  (in_tvalid),
    .in_axis_tready  (in_tready),
    .in_axis_tlast   (in_tlast),
    .in_axis_tuser   (in_tuser),
    .out_axis_tdata  (out_tdata),
    .out_axis_tkeep  (out_tkeep),
    .out_axis_tvalid (out_valid),
    .out_axis_tready (out_tready),
    .out_axis_tlast  (out_tlast),
    .out_axis_tuser  (out_tuser),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_port(input int p, input logic [63:0] d, input logic [7:0] k, input logic l,
                          input logic v);
    in_tdata[p*64 +: 64] = d;
    in_tkeep[p*8 +: 8]   = k;
    in_tlast[p]          = l;
    in_tuser[p]          = 1'b0;
    in_tvalid[p]         = v;
  endtask

  // Present one beat on port p and hold it until the arbiter takes it.
  task automatic push_beat(input int p, input logic [63:0] d, input logic [7:0] k, input logic l);
    bit hs = 1'b0;
    set_port(p, d, k, l, 1'b1);
    for (int c = 0; c < 40 && !hs; c++) begin
      @(negedge clk);
      hs = in_tready[p];
      @(posedge clk);
      #1;
    end
    in_tvalid[p] = 1'b0;
    chk("push_handshake", {127'd0, hs}, 128'd1);
  endtask

  // Random-phase source: first beat of a frame is always offered at once, later beats may gap.
  task automatic drive_port(input int p, input bit hs);
    beat_t b;
    if (pos[p] >= src_q[p].size()) begin
      in_tvalid[p] = 1'b0;
    end else if (hs || !in_tvalid[p]) begin
      b = src_q[p][pos[p]];
      in_tdata[p*64 +: 64] = b.d;
      in_tkeep[p*8 +: 8]   = b.k;
      in_tlast[p]          = b.l;
      in_tuser[p]          = b.u;
      if (pos[p] == 0) in_tvalid[p] = 1'b1;
      else if (src_q[p][pos[p]-1].l) in_tvalid[p] = 1'b1;
      else in_tvalid[p] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    beat_t cur, held, e;
    bit    hold;
    bit    hs [NP];
    int    got, n_exp, ptr, remaining;

    // Reset with every requester asserting valid
    rst_n      = 1'b0;
    out_tready = 1'b1;
    set_port(0, 64'hD0D0_0000_0000_0001, 8'hFF, 1'b1, 1'b1);
    set_port(1, 64'hD1D1_0000_0000_0002, 8'hFF, 1'b1, 1'b1);
    #3;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_tready", {126'd0, in_tready}, 128'd0);
    chk("rst_grant", {126'd0, grant}, 128'd0);
    chk("rst_busy_terr", {126'd0, busy, timeout_err}, 128'd0);
    chk("rst_out_data", {64'd0, out_tdata}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_grant", {126'd0, grant}, 128'd1);
    chk("first_no_data_yet", {127'd0, out_valid}, 128'd0);
    chk("first_busy", {127'd0, busy}, 128'd1);
    @(posedge clk); #1;
    chk("first_data", {63'd0, out_valid, out_tdata}, {63'd0, 1'b1, 64'hD0D0_0000_0000_0001});
    in_tvalid[0] = 1'b0;
    @(posedge clk); #1;
    chk("second_grant", {126'd0, grant}, 128'd2);
    @(posedge clk); #1;
    chk("second_data", {63'd0, out_valid, out_tdata}, {63'd0, 1'b1, 64'hD1D1_0000_0000_0002});
    in_tvalid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back single-beat frames from port 1 only
    set_port(1, 64'h5151_5151_5151_5151, 8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("single_rate", {127'd0, out_valid}, {127'd0, (i % 2) == 1});
      if (out_valid) chk("single_keep", {120'd0, out_tkeep}, {120'd0, 8'h0F});
    end
    in_tvalid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Mid-frame reset: move the pointer to 1, then cut a 6-beat port-1 frame on beat 3
    push_beat(0, 64'hC0, 8'hFF, 1'b1);
    push_beat(1, 64'hE0, 8'hFF, 1'b0);
    push_beat(1, 64'hE1, 8'hFF, 1'b0);
    push_beat(1, 64'hE2, 8'hFF, 1'b0);
    chk("pre_reset_data", {63'd0, out_valid, out_tdata}, {63'd0, 1'b1, 64'hE2});
    set_port(1, 64'hE3, 8'hFF, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {63'd0, out_valid, out_tdata}, 128'd0);
    chk("midrst_ctrl", {122'd0, grant, in_tready, busy, timeout_err}, 128'd0);
    set_port(0, 64'hF0, 8'hFF, 1'b1, 1'b1);
    set_port(1, 64'hF1, 8'hFF, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_grant", {126'd0, grant}, 128'd1);
    push_beat(0, 64'hF0, 8'hFF, 1'b1);
    push_beat(1, 64'hF1, 8'hFF, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // Randomized frames on both ports; pointer is 0 here
    for (int p = 0; p < NP; p++) begin
      pos[p] = 0;
      for (int f = 0; f < 6; f++) begin
        int len;
        len = $urandom_range(1, 8);
        flen[p].push_back(len);
        for (int b = 0; b < len; b++) begin
          src_q[p].push_back('{d: {$urandom, $urandom}, k: 8'($urandom), l: (b == len - 1),
                               u: 1'($urandom)});
        end
      end
    end
    // Every port with frames left is requesting at each arbitration, so the order is plain RR
    begin
      int fi [NP];
      int off [NP];
      ptr = 0;
      remaining = 0;
      for (int p = 0; p < NP; p++) begin
        fi[p] = 0;
        off[p] = 0;
        remaining += flen[p].size();
      end
      while (remaining > 0) begin
        int sel;
        sel = -1;
        for (int k = 0; k < NP; k++) begin
          if (sel < 0 && fi[(ptr + k) % NP] < flen[(ptr + k) % NP].size()) sel = (ptr + k) % NP;
        end
        for (int b = 0; b < flen[sel][fi[sel]]; b++) exp_q.push_back(src_q[sel][off[sel] + b]);
        off[sel] += flen[sel][fi[sel]];
        fi[sel]++;
        ptr = (sel + 1) % NP;
        remaining--;
      end
    end
    n_exp = exp_q.size();
    got   = 0;
    hold  = 1'b0;
    held  = '0;
    for (int p = 0; p < NP; p++) drive_port(p, 1'b0);
    out_tready = ($urandom_range(0, 2) != 0);
    for (int c = 0; c < 5000 && got < n_exp; c++) begin
      @(negedge clk);
      cur = {out_tdata, out_tkeep, out_tlast, out_tuser};
      if (hold) chk("stall_stable", {53'd0, out_valid, cur}, {53'd0, 1'b1, held});
      chk("tready_only_owner", {126'd0, in_tready & ~grant}, 128'd0);
      if (out_valid && out_tready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("rand_beat", {54'd0, cur}, {54'd0, e});
        got++;
      end
      hold = out_valid && !out_tready;
      held = cur;
      for (int p = 0; p < NP; p++) hs[p] = in_tvalid[p] && in_tready[p];
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p]) pos[p]++;
        drive_port(p, hs[p]);
      end
      out_tready = ($urandom_range(0, 2) != 0);
    end
    chk("rand_beat_count", 128'(got), 128'(n_exp));
    in_tvalid  = '0;
    out_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

`ifdef ARB_TIMEOUT_EN
    // Port 0 stalls after two beats of a 5-beat frame; port 1 waits with one single-beat frame
    begin
      beat_t ob [$];
      beat_t exp6 [4];
      int    to_cnt, p0, stall;
      bit    p1_done, hs0, hs1;
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n   = 1'b1;
      to_cnt  = 0;
      p0      = 0;
      stall   = 0;
      p1_done = 1'b0;
      for (int c = 0; c < 80; c++) begin
        set_port(0, 64'hA000 + 64'(p0), 8'hFF, p0 == 4, (p0 < 5) && !(p0 == 2 && stall < 20));
        set_port(1, 64'hB1, 8'hFF, 1'b1, !p1_done);
        @(negedge clk);
        if (out_valid) ob.push_back({out_tdata, out_tkeep, out_tlast, out_tuser});
        if (timeout_err) to_cnt++;
        hs0 = in_tvalid[0] && in_tready[0];
        hs1 = in_tvalid[1] && in_tready[1];
        if (p0 == 2 && !in_tvalid[0]) stall++;
        @(posedge clk); #1;
        if (hs0) p0++;
        if (hs1) p1_done = 1'b1;
      end
      exp6[0] = '{d: 64'hA000, k: 8'hFF, l: 1'b0, u: 1'b0};
      exp6[1] = '{d: 64'hA001, k: 8'hFF, l: 1'b0, u: 1'b0};
      exp6[2] = '{d: 64'h0,    k: 8'h01, l: 1'b1, u: 1'b1};
      exp6[3] = '{d: 64'hB1,   k: 8'hFF, l: 1'b1, u: 1'b0};
      chk("abort_beat_count", 128'(ob.size()), 128'd4);
      for (int i = 0; i < 4 && i < ob.size(); i++) chk("abort_seq", {54'd0, ob[i]}, {54'd0, exp6[i]});
      chk("timeout_pulses", 128'(to_cnt), 128'd1);
      chk("drain_consumed", 128'(p0), 128'd5);
      in_tvalid = '0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
